elevator_dispatcher: RTL

- Central hall-call scheduler for the two-car elevator system over 4 floors.
- Latches hall up/down call pulses into pending registers and picks one pending call at a time.
- Assigns the picked call to the nearest idle car over a valid/ack handshake.
- Sits above the per-car elevator controllers: each controller takes its carX_target as its requested floor and acks on acceptance.

---
 rtl/elevator_dispatcher.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/elevator_dispatcher.sv
// Hall-call dispatcher for a two-car, four-floor elevator bank. It latches hall calls,
// picks one pending call at a time, and offers it to the nearest idle car over valid/ack.
module elevator_dispatcher #(
    parameter int NUM_FLOORS  = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_FLOORS-1:0]         hall_up_req,
    input  logic [NUM_FLOORS-1:0]         hall_dn_req,
    input  logic [$clog2(NUM_FLOORS)-1:0] car0_floor,
    input  logic [$clog2(NUM_FLOORS)-1:0] car1_floor,
    input  logic                          car0_idle,
    input  logic                          car1_idle,
    input  logic                          emergency,
    output logic [$clog2(NUM_FLOORS)-1:0] car0_target,
    output logic                          car0_valid,
    input  logic                          car0_ack,
    output logic [$clog2(NUM_FLOORS)-1:0] car1_target,
    output logic                          car1_valid,
    input  logic                          car1_ack,
    output logic [NUM_FLOORS-1:0]         pending_up,
    output logic [NUM_FLOORS-1:0]         pending_dn,
    output logic                          emergency_active
);
    localparam int FW = $clog2(NUM_FLOORS);
    localparam logic [NUM_FLOORS-1:0] UP_MASK = {1'b0, {(NUM_FLOORS-1){1'b1}}};
    localparam logic [NUM_FLOORS-1:0] DN_MASK = {{(NUM_FLOORS-1){1'b1}}, 1'b0};
    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        SCAN  = 2'd0,
        OFFER = 2'd1,
        EMERG = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_FLOORS-1:0]   pend_up_q, pend_up_d;
    logic [NUM_FLOORS-1:0]   pend_dn_q, pend_dn_d;
    logic [NUM_FLOORS-1:0]   clr_up, clr_dn;
    logic [FW-1:0]           call_floor_q, call_floor_d;
    logic                    call_up_q, call_up_d;
    logic                    car_q, car_d;
    logic                    rr_q, rr_d;
    logic [7:0]              tmo_q, tmo_d;
    logic [1:0]              excl_q, excl_d;
    logic                    valid0_q, valid0_d;
    logic                    valid1_q, valid1_d;
    logic [FW-1:0]           tgt0_q, tgt0_d;
    logic [FW-1:0]           tgt1_q, tgt1_d;

    logic                    call_found;
    logic [FW-1:0]           call_floor;
    logic                    call_up;
    logic                    elig0, elig1;
    logic [FW-1:0]           dist0, dist1;
    logic                    pick_ok, pick_car, pick_tie;
    logic                    offered_ack;

    function automatic logic [FW-1:0] floor_dist(input logic [FW-1:0] a, input logic [FW-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Lowest-priority candidates are visited first so the last hit is the winner:
    // down calls top to bottom, then up calls top to bottom (up floor 0 ends up best).
    always_comb begin
        call_found = 1'b0;
        call_floor = '0;
        call_up    = 1'b0;
        for (int i = NUM_FLOORS - 1; i >= 1; i--) begin
            if (pend_dn_q[i]) begin
                call_found = 1'b1;
                call_floor = FW'(i);
                call_up    = 1'b0;
            end
        end
        for (int i = NUM_FLOORS - 2; i >= 0; i--) begin
            if (pend_up_q[i]) begin
                call_found = 1'b1;
                call_floor = FW'(i);
                call_up    = 1'b1;
            end
        end
    end

    assign elig0 = car0_idle & ~excl_q[0];
    assign elig1 = car1_idle & ~excl_q[1];
    assign dist0 = floor_dist(car0_floor, call_floor);
    assign dist1 = floor_dist(car1_floor, call_floor);

    always_comb begin
        pick_car = 1'b0;
        pick_tie = 1'b0;
        if (elig0 && elig1) begin
            if (dist0 < dist1) begin
                pick_car = 1'b0;
            end else if (dist1 < dist0) begin
                pick_car = 1'b1;
            end else begin
                pick_car = rr_q;
                pick_tie = 1'b1;
            end
        end else if (elig1) begin
            pick_car = 1'b1;
        end
        pick_ok = call_found & (elig0 | elig1);
    end

    assign offered_ack = car_q ? car1_ack : car0_ack;

    always_comb begin
        state_d      = state_q;
        call_floor_d = call_floor_q;
        call_up_d    = call_up_q;
        car_d        = car_q;
        rr_d         = rr_q;
        tmo_d        = tmo_q;
        excl_d       = excl_q;
        valid0_d     = valid0_q;
        valid1_d     = valid1_q;
        tgt0_d       = tgt0_q;
        tgt1_d       = tgt1_q;
        clr_up       = '0;
        clr_dn       = '0;

        if (emergency) begin
            // Emergency overrides any ack or timeout arriving in the same cycle.
            state_d  = EMERG;
            valid0_d = 1'b0;
            valid1_d = 1'b0;
        end else begin
            case (state_q)
                SCAN: begin
                    if (!call_found) begin
                        excl_d = '0;
                    end
                    if (pick_ok) begin
                        state_d      = OFFER;
                        call_floor_d = call_floor;
                        call_up_d    = call_up;
                        car_d        = pick_car;
                        tmo_d        = '0;
                        if (pick_tie) begin
                            rr_d = ~rr_q;
                        end
                        if (pick_car) begin
                            valid1_d = 1'b1;
                            tgt1_d   = call_floor;
                        end else begin
                            valid0_d = 1'b1;
                            tgt0_d   = call_floor;
                        end
                    end
                end
                OFFER: begin
                    if (offered_ack) begin
                        clr_up[call_floor_q] = call_up_q;
                        clr_dn[call_floor_q] = ~call_up_q;
                        valid0_d             = 1'b0;
                        valid1_d             = 1'b0;
                        state_d              = SCAN;
                    end else if (tmo_q == TMO_LAST) begin
                        valid0_d       = 1'b0;
                        valid1_d       = 1'b0;
                        excl_d[car_q]  = 1'b1;
                        state_d        = SCAN;
                    end else begin
                        tmo_d = tmo_q + 8'd1;
                    end
                end
                EMERG: begin
                    state_d = SCAN;
                end
                default: begin
                    state_d = SCAN;
                end
            endcase
        end

        // Set beats clear on the same bit, so a repeat call during its own ack stays lit.
        pend_up_d = (pend_up_q & ~clr_up) | (hall_up_req & UP_MASK);
        pend_dn_d = (pend_dn_q & ~clr_dn) | (hall_dn_req & DN_MASK);
        if (emergency || (state_q == EMERG)) begin
            pend_up_d = '0;
            pend_dn_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= SCAN;
            pend_up_q    <= '0;
            pend_dn_q    <= '0;
            call_floor_q <= '0;
            call_up_q    <= 1'b0;
            car_q        <= 1'b0;
            rr_q         <= 1'b0;
            tmo_q        <= '0;
            excl_q       <= '0;
            valid0_q     <= 1'b0;
            valid1_q     <= 1'b0;
            tgt0_q       <= '0;
            tgt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            pend_up_q    <= pend_up_d;
            pend_dn_q    <= pend_dn_d;
            call_floor_q <= call_floor_d;
            call_up_q    <= call_up_d;
            car_q        <= car_d;
            rr_q         <= rr_d;
            tmo_q        <= tmo_d;
            excl_q       <= excl_d;
            valid0_q     <= valid0_d;
            valid1_q     <= valid1_d;
            tgt0_q       <= tgt0_d;
            tgt1_q       <= tgt1_d;
        end
    end

    assign car0_valid       = valid0_q;
    assign car1_valid       = valid1_q;
    assign car0_target      = tgt0_q;
    assign car1_target      = tgt1_q;
    assign pending_up       = pend_up_q;
    assign pending_dn       = pend_dn_q;
    assign emergency_active = (state_q == EMERG);

endmodule
